// File: rtl/single_neuron_2_pkg.sv
// Shared types and constants for the single_neuron_2 compute block.
//   state_e    : control FSM state encoding (IDLE, MAC, DONE)
//   acc_width  : accumulator width that cannot overflow for N products
//   sat_limit  : largest positive result representable in the 2*WIDTH output
package single_neuron_2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // 2*WIDTH bits per product plus clog2(N) growth bits for the sum.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned width);
        return 2 * width + $clog2(n);
    endfunction

    // Signed maximum of the 2*WIDTH result, so the output MSB stays 0.
    function automatic int unsigned sat_limit(input int unsigned width);
        return (32'd1 << (2 * width - 1)) - 32'd1;
    endfunction

    localparam int unsigned SAT_MAX_W8 = sat_limit(8);

endpackage

// File: rtl/vector_select.sv
// Operand storage for one neuron: input and weight vectors, read by index.
//   idx_i : element index driven by the neuron FSM
//   in_o  : in_vec[idx_i], combinational
//   w_o   : w_vec[idx_i], combinational
// The arrays are preloaded by backdoor (file load / hierarchical write) and
// are neither reset nor written by any logic here.
module vector_select #(
    parameter int unsigned N     = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] in_o,
    output logic [WIDTH-1:0] w_o
);

    logic [WIDTH-1:0] in_vec [0:N-1];
    logic [WIDTH-1:0] w_vec  [0:N-1];

    // Index never exceeds N-1; the FSM wraps it after the last element.
    assign in_o = in_vec[idx_i];
    assign w_o  = w_vec[idx_i];

endmodule

// File: rtl/single_neuron_2.sv
// Single-neuron compute unit: on start, walks N stored input/weight pairs,
// accumulates the signed dot product, applies ReLU and positive saturation,
// and presents the result with a ready flag.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   start : level request, one computation per request while held
//   out   : 2*WIDTH-bit result, unsigned after ReLU (MSB always 0)
//   ready : high while out holds a valid result
module single_neuron_2
    import single_neuron_2_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   out,
    output logic                 ready
);

    localparam int unsigned OUT_W = 2 * WIDTH;
    localparam int unsigned ACC_W = acc_width(N, WIDTH);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned EXT_W = ACC_W - OUT_W;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(sat_limit(WIDTH));

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q,   idx_d;
    logic signed [ACC_W-1:0]   acc_q,   acc_d;
    logic [OUT_W-1:0]          out_q,   out_d;
    logic                      ready_q, ready_d;

    logic [WIDTH-1:0]          in_sel;
    logic [WIDTH-1:0]          w_sel;
    logic signed [OUT_W-1:0]   in_ext;
    logic signed [OUT_W-1:0]   w_ext;
    logic signed [OUT_W-1:0]   prod_c;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [OUT_W-1:0]          result_c;

    // Operand storage and index mux.
    vector_select #(
        .N     (N),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) sel (
        .idx_i (idx_q),
        .in_o  (in_sel),
        .w_o   (w_sel)
    );

    // Signed product; |a*b| <= 2^(2W-2), so 2*WIDTH bits hold it exactly.
    assign in_ext   = {{WIDTH{in_sel[WIDTH-1]}}, in_sel};
    assign w_ext    = {{WIDTH{w_sel[WIDTH-1]}}, w_sel};
    assign prod_c   = in_ext * w_ext;
    assign prod_ext = {{EXT_W{prod_c[OUT_W-1]}}, prod_c};

    // ReLU followed by clamp to the largest positive 2*WIDTH value.
    always_comb begin
        result_c = '0;
        if (acc_q[ACC_W-1]) begin
            result_c = '0;
        end else if (acc_q > SAT_MAX) begin
            result_c = SAT_MAX[OUT_W-1:0];
        end else begin
            result_c = acc_q[OUT_W-1:0];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ready_d = ready_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                // acc is stable here, so re-latching while start is held is harmless.
                out_d   = result_c;
                ready_d = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign out   = out_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_single_neuron_2.sv
// Self-checking bench for single_neuron_2 with N=16 and N=10 instances.
module tb_single_neuron_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16;
    logic        start10;
    logic [15:0] out16;
    logic [15:0] out10;
    logic        ready16;
    logic        ready10;

    int n_checks = 0;
    int n_fail   = 0;
    int in_m [16];
    int w_m  [16];

    always #5 clk = ~clk;

    single_neuron_2 #(.N(16), .WIDTH(8)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .out   (out16),
        .ready (ready16)
    );

    single_neuron_2 #(.N(10), .WIDTH(8)) dut10 (
        .clk   (clk),
        .rst   (rst),
        .start (start10),
        .out   (out10),
        .ready (ready10)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: dot product, ReLU, clamp to 32767.
    function automatic int model(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(in_m[i]) * longint'(w_m[i]);
        if (s < 0) return 0;
        if (s > 32767) return 32767;
        return int'(s);
    endfunction

    function automatic int rnd8();
        logic [7:0] b;
        b = 8'($urandom);
        return int'($signed(b));
    endfunction

    task automatic load16();
        for (int i = 0; i < 16; i++) begin
            dut16.sel.in_vec[i] = 8'(in_m[i]);
            dut16.sel.w_vec[i]  = 8'(w_m[i]);
        end
    endtask

    task automatic load10();
        for (int i = 0; i < 10; i++) begin
            dut10.sel.in_vec[i] = 8'(in_m[i]);
            dut10.sel.w_vec[i]  = 8'(w_m[i]);
        end
    endtask

    task automatic fill(input int a, input int b);
        for (int i = 0; i < 16; i++) begin
            in_m[i] = a;
            w_m[i]  = b;
        end
    endtask

    // mode 0: one-cycle pulse, 1: random start during MAC, 2: hold start high.
    task automatic run16(input string tag, input int mode);
        int exp;
        exp = model(16);
        start16 = 1'b1;
        tick();
        check({tag, "_accept_rdy"}, 32'(ready16), 0);
        for (int c = 1; c <= 16; c++) begin
            if (mode == 1)      start16 = 1'($urandom_range(0, 1));
            else if (mode == 2) start16 = 1'b1;
            else                start16 = 1'b0;
            tick();
            check({tag, "_busy_rdy"}, 32'(ready16), 0);
        end
        start16 = (mode == 2) ? 1'b1 : 1'b0;
        tick();
        check({tag, "_rdy"}, 32'(ready16), 1);
        check({tag, "_out"}, 32'(out16), 32'(exp));
        if (mode == 2) begin
            for (int c = 0; c < 50; c++) begin
                tick();
                check({tag, "_hold_rdy"}, 32'(ready16), 1);
                check({tag, "_hold_out"}, 32'(out16), 32'(exp));
            end
        end
        start16 = 1'b0;
        tick();
        check({tag, "_idle_rdy"}, 32'(ready16), 1);
        check({tag, "_idle_out"}, 32'(out16), 32'(exp));
    endtask

    task automatic run10(input string tag, input bit toggle);
        int exp;
        exp = model(10);
        start10 = 1'b1;
        tick();
        check({tag, "_accept_rdy"}, 32'(ready10), 0);
        for (int c = 1; c <= 10; c++) begin
            start10 = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            check({tag, "_busy_rdy"}, 32'(ready10), 0);
        end
        start10 = 1'b0;
        tick();
        check({tag, "_rdy"}, 32'(ready10), 1);
        check({tag, "_out"}, 32'(out10), 32'(exp));
        tick();
    endtask

    initial begin
        // Reset held with an unknown start request.
        rst     = 1'b0;
        start16 = 1'bx;
        start10 = 1'b0;
        repeat (3) tick();
        check("rst_out16", 32'(out16), 0);
        check("rst_rdy16", 32'(ready16), 0);
        check("rst_out10", 32'(out10), 0);
        check("rst_rdy10", 32'(ready10), 0);
        start16 = 1'b0;
        rst     = 1'b1;
        repeat (2) tick();
        check("post_rst_rdy16", 32'(ready16), 0);
        check("post_rst_out16", 32'(out16), 0);

        // All ones -> 16.
        fill(1, 1);
        load16();
        run16("ones", 0);

        // in[i]=i, w=2 -> 240; hold start, then re-request.
        for (int i = 0; i < 16; i++) begin
            in_m[i] = i;
            w_m[i]  = 2;
        end
        load16();
        run16("ramp_hold", 2);
        run16("ramp_again", 0);

        // Negative sum clipped to 0, then saturation.
        fill(2, -3);
        load16();
        run16("relu", 0);
        fill(-128, -128);
        load16();
        run16("sat", 0);

        // N=10 with a dominant last weight -> 455.
        fill(5, -1);
        w_m[9] = 100;
        load10();
        run10("n10", 1'b0);

        // Reset during MAC at idx=7, then restart on the release edge.
        for (int i = 0; i < 16; i++) begin
            in_m[i] = i;
            w_m[i]  = 2;
        end
        load16();
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b0;
        #1;
        check("midmac_rst_out", 32'(out16), 0);
        check("midmac_rst_rdy", 32'(ready16), 0);
        check("midmac_rst_out10", 32'(out10), 0);
        tick();
        tick();
        check("midmac_held_out", 32'(out16), 0);
        rst = 1'b1;
        run16("after_rst", 0);

        // Randomized vectors, some biased to the extremes.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) begin
                if (t % 3 == 2) begin
                    in_m[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
                    w_m[i]  = ($urandom_range(0, 1) == 1) ? 127 : -128;
                end else begin
                    in_m[i] = rnd8();
                    w_m[i]  = rnd8();
                end
            end
            load16();
            run16("rand16", 1);
        end
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) begin
                in_m[i] = rnd8();
                w_m[i]  = (t == 3) ? rnd8() / 8 + 20 : rnd8();
            end
            load10();
            run10("rand10", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
